exec_unit: RTL and testbench
============================

Name: exec_unit

Overview:
- Execute/write-back stage directly downstream of the program counter and instruction fetch path.
- Accepts one 16-bit instruction per handshake and executes it against an internal 16x8 register file.
- Supported operations: ADD, SUB, ADDI and SW. SW drives a data-memory write port.
- Runs a 4-state multi-cycle FSM and pulses pc_inc to advance the upstream program counter once per retired instruction.

Parameters:
- DW, 8: data/register width in bits.
- RF_DEPTH, 16: number of registers; register address width is fixed at 4.
- IW, 16: instruction width; the field layout below is fixed for IW=16.

Ports:
- clk  input  1  system clock; all state changes on the rising edge.
- rst  input  1  asynchronous, active-low reset (0 = reset asserted).
- instr  input  IW  instruction word, sampled on handshake.
- instr_valid  input  1  upstream has a valid instr.
- instr_ready  output  1  unit can accept an instruction (high only in IDLE).
- pc_inc  output  1  one-cycle pulse in WB; upstream PC advances by 1.
- mem_we  output  1  data-memory write strobe, one-cycle pulse.
- mem_addr  output  DW  data-memory address.
- mem_wdata  output  DW  data-memory write data.
- out  output  DW  result of the last retired ADD/SUB/ADDI, or SW address.
- illegal  output  1  one-cycle pulse in WB for an undefined opcode.
- dbg_addr  input  4  register-file debug read address.
- dbg_data  output  DW  combinational read of rf[dbg_addr].

Behaviour:
- Instruction fields:
  - [15:12] oper
  - [11:8] A_add (rd / SW source)
  - [7:4] B_add (rs / SW base)
  - [3:0] imm4
  - imm4 is sign-extended to DW.
- Opcodes:
  - 0000 NOP: no state change except pc_inc.
  - 0010 ADD: rf[A] = rf[A] + rf[B].
  - 0011 SUB: rf[A] = rf[A] - rf[B].
  - 0100 ADDI: rf[A] = rf[A] + sext(imm4).
  - 0101 SW: mem[rf[B] + sext(imm4)] = rf[A].
  - Any other opcode behaves as NOP and pulses illegal in WB.
- Arithmetic is modulo 2^DW; no carry/flag outputs. 0xFF + 0x01 = 0x00, 0x00 - 0x01 = 0xFF.
- FSM states: IDLE -> DECODE -> EXEC -> WB -> IDLE.
  - IDLE: instr_ready = 1. On instr_valid & instr_ready, latch instr and go to DECODE. Otherwise stay.
  - DECODE: latch opA = rf[A_add], opB = rf[B_add], sext(imm4), opcode.
  - EXEC: compute and register the result; for SW, register mem_addr and mem_wdata.
  - WB, for one cycle:
    - pc_inc = 1.
    - ADD/SUB/ADDI: write rf[A_add] and update out.
    - SW: mem_we = 1 and out = store address.
    - Illegal opcode: illegal = 1.
- Latency: handshake at edge N; register-file write (or mem_we) is visible after edge N+3. Throughput is 1 instruction per 4 cycles.
- instr_ready is low in DECODE/EXEC/WB. instr and instr_valid are ignored in those states; no buffering.
- Operands are read in DECODE, so A_add == B_add uses the same old value for both operands (ADD r1,r1 doubles r1).
- mem_addr and mem_wdata hold their last values when mem_we is low.
- dbg_data reflects a WB write from the cycle after that write's edge.
- Reset (rst = 0, asynchronous), with all values held while rst = 0:
  - FSM to IDLE.
  - All rf entries = 0.
  - out = 0, mem_addr = 0, mem_wdata = 0.
  - mem_we = 0, pc_inc = 0, illegal = 0.
  - instr_ready = 1 while in IDLE, including right after reset release.
- Reset mid-instruction aborts it: no rf write, mem_we or pc_inc for that instruction. The first handshake after release restarts cleanly.
- Reset release is synchronised to clk; the first handshake happens at the first rising edge after release.

Test Plan:
- Reset then ADDI r1,+5 (instr 0x4105) -> after 4 cycles rf[1] = 0x05, out = 0x05, one pc_inc pulse, mem_we = 0.
- ADDI r2,-1 (0x420F) from reset -> rf[2] = 0xFF. Then ADD r2,r1 with r1 = 0x01 (0x2210) -> rf[2] = 0x00 (wrap).
- SUB r3,r1 (0x3310) with r3 = 0, r1 = 5 -> rf[3] = 0xFB. SUB r1,r1 (0x3110) -> rf[1] = 0x00.
- SW r1 = 0x05 to [r2 + 3] with r2 = 0x10 (0x5123) -> single-cycle mem_we, mem_addr = 0x13, mem_wdata = 0x05, out = 0x13, no rf change.
- Back-to-back instr_valid held high with 3 instructions -> instr_ready high exactly 1 cycle in 4, exactly 3 pc_inc pulses. Opcode 0x7 -> illegal pulse and no state change.
- Assert rst low during EXEC of ADDI r4,+2 -> rf[4] = 0, no pc_inc. After release, ADDI r4,+2 completes normally with rf[4] = 0x02.

Source files
------------

// File: rtl/exec_unit.sv
// Execute/write-back stage: runs ADD/SUB/ADDI/SW from a 16x8 register file through IDLE/DECODE/EXEC/WB.
// Latency: handshake at edge N, register write or store retired by edge N+3; one instruction per 4 cycles.
// Backpressure: instr_ready only in IDLE; instructions presented in other states are ignored, never buffered.
module exec_unit #(
    parameter int DW       = 8,
    parameter int RF_DEPTH = 16,
    parameter int IW       = 16
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [IW-1:0] instr,
    input  logic          instr_valid,
    output logic          instr_ready,
    output logic          pc_inc,
    output logic          mem_we,
    output logic [DW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    output logic [DW-1:0] out,
    output logic          illegal,
    input  logic [3:0]    dbg_addr,
    output logic [DW-1:0] dbg_data
);

    localparam logic [3:0] OP_NOP  = 4'b0000;
    localparam logic [3:0] OP_ADD  = 4'b0010;
    localparam logic [3:0] OP_SUB  = 4'b0011;
    localparam logic [3:0] OP_ADDI = 4'b0100;
    localparam logic [3:0] OP_SW   = 4'b0101;

    typedef enum logic [1:0] {
        S_IDLE,
        S_DECODE,
        S_EXEC,
        S_WB
    } state_t;

    state_t state, state_nxt;

    logic [RF_DEPTH-1:0][DW-1:0] rf;
    logic [IW-1:0] instr_q;
    logic [3:0]    op_q;
    logic [3:0]    a_q;
    logic [DW-1:0] opa_q;
    logic [DW-1:0] opb_q;
    logic [DW-1:0] imm_q;
    logic [DW-1:0] res_q;
    logic          is_alu;
    logic          is_legal;

    assign is_alu   = (op_q == OP_ADD) || (op_q == OP_SUB) || (op_q == OP_ADDI);
    assign is_legal = is_alu || (op_q == OP_SW) || (op_q == OP_NOP);
    assign dbg_data = rf[dbg_addr];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        instr_ready = 1'b0;
        pc_inc      = 1'b0;
        mem_we      = 1'b0;
        illegal     = 1'b0;
        case (state)
            S_IDLE: begin
                instr_ready = 1'b1;
                if (instr_valid) begin
                    state_nxt = S_DECODE;
                end
            end
            S_DECODE: state_nxt = S_EXEC;
            S_EXEC:   state_nxt = S_WB;
            S_WB: begin
                pc_inc    = 1'b1;
                mem_we    = (op_q == OP_SW);
                illegal   = !is_legal;
                state_nxt = S_IDLE;
            end
            default:  state_nxt = S_IDLE;
        endcase
    end

    // Operands are captured in DECODE, so rd == rs sees the same pre-instruction value twice.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rf        <= '0;
            instr_q   <= '0;
            op_q      <= '0;
            a_q       <= '0;
            opa_q     <= '0;
            opb_q     <= '0;
            imm_q     <= '0;
            res_q     <= '0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            out       <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (instr_valid) begin
                        instr_q <= instr;
                    end
                end
                S_DECODE: begin
                    op_q  <= instr_q[15:12];
                    a_q   <= instr_q[11:8];
                    opa_q <= rf[instr_q[11:8]];
                    opb_q <= rf[instr_q[7:4]];
                    imm_q <= {{(DW-4){instr_q[3]}}, instr_q[3:0]};
                end
                S_EXEC: begin
                    case (op_q)
                        OP_ADD:  res_q <= opa_q + opb_q;
                        OP_SUB:  res_q <= opa_q - opb_q;
                        OP_ADDI: res_q <= opa_q + imm_q;
                        OP_SW: begin
                            mem_addr  <= opb_q + imm_q;
                            mem_wdata <= opa_q;
                        end
                        default: ;
                    endcase
                end
                S_WB: begin
                    if (is_alu) begin
                        rf[a_q] <= res_q;
                        out     <= res_q;
                    end else if (op_q == OP_SW) begin
                        out <= mem_addr;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_exec_unit.sv
// Directed bench for exec_unit: hand-computed register, output and strobe values per instruction.
module tb_exec_unit;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [15:0] instr = '0;
    logic        instr_valid = 1'b0;
    logic        instr_ready;
    logic        pc_inc;
    logic        mem_we;
    logic [7:0]  mem_addr;
    logic [7:0]  mem_wdata;
    logic [7:0]  out;
    logic        illegal;
    logic [3:0]  dbg_addr = '0;
    logic [7:0]  dbg_data;

    int errs   = 0;
    int checks = 0;

    int         g_pc;
    int         g_we;
    int         g_ill;
    logic [7:0] g_addr;
    logic [7:0] g_wdata;

    exec_unit dut (
        .clk        (clk),
        .rst        (rst),
        .instr      (instr),
        .instr_valid(instr_valid),
        .instr_ready(instr_ready),
        .pc_inc     (pc_inc),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .out        (out),
        .illegal    (illegal),
        .dbg_addr   (dbg_addr),
        .dbg_data   (dbg_data)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
        checks++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic rd_reg(input logic [3:0] a, output logic [7:0] v);
        dbg_addr = a;
        #1;
        v = dbg_data;
    endtask

    task automatic chk_reg(input string tag, input logic [3:0] a, input logic [7:0] exp);
        logic [7:0] v;
        rd_reg(a, v);
        chk(tag, {8'h00, v}, {8'h00, exp});
    endtask

    // Issues one instruction from IDLE and returns at the negedge after WB with strobe counts captured.
    task automatic run_instr(input logic [15:0] ins);
        g_pc  = 0;
        g_we  = 0;
        g_ill = 0;
        @(negedge clk);
        instr       = ins;
        instr_valid = 1'b1;
        @(posedge clk);
        #1 instr_valid = 1'b0;
        repeat (3) begin
            @(negedge clk);
            g_pc  += int'(pc_inc);
            g_we  += int'(mem_we);
            g_ill += int'(illegal);
            if (mem_we) begin
                g_addr  = mem_addr;
                g_wdata = mem_wdata;
            end
        end
        @(negedge clk);
    endtask

    initial begin
        logic [15:0] prog [3];
        int rdy_cnt;
        int pc_cnt;
        int k;

        // Reset state
        repeat (2) @(negedge clk);
        chk("rst_ready", 16'(instr_ready), 16'd1);
        chk("rst_pc_inc", 16'(pc_inc), 16'd0);
        chk("rst_mem_we", 16'(mem_we), 16'd0);
        chk("rst_illegal", 16'(illegal), 16'd0);
        chk("rst_out", 16'(out), 16'h00);
        chk("rst_mem_addr", 16'(mem_addr), 16'h00);
        chk_reg("rst_r1", 4'd1, 8'h00);
        rst = 1'b1;

        // ADDI r1,+5
        run_instr(16'h4105);
        chk_reg("addi_r1", 4'd1, 8'h05);
        chk("addi_out", 16'(out), 16'h05);
        chk("addi_pc_cnt", 16'(g_pc), 16'd1);
        chk("addi_we_cnt", 16'(g_we), 16'd0);

        // ADDI r2,-1; ADDI r1,-4; ADD r2,r1 wraps
        run_instr(16'h420F);
        chk_reg("addi_neg_r2", 4'd2, 8'hFF);
        run_instr(16'h411C);
        chk_reg("addi_r1_to1", 4'd1, 8'h01);
        run_instr(16'h2210);
        chk_reg("add_wrap_r2", 4'd2, 8'h00);
        chk("add_wrap_out", 16'(out), 16'h00);

        // r1 back to 5; SUB r3,r1 underflows; SUB r1,r1 clears
        run_instr(16'h4114);
        run_instr(16'h3310);
        chk_reg("sub_r3", 4'd3, 8'hFB);
        chk("sub_out", 16'(out), 16'hFB);
        run_instr(16'h3110);
        chk_reg("sub_self_r1", 4'd1, 8'h00);

        // r1 = 5, r2 = 0x10 via doubling, then SW r1 -> [r2+3]
        run_instr(16'h4105);
        run_instr(16'h4204);
        run_instr(16'h2220);
        chk_reg("add_dbl_r2", 4'd2, 8'h08);
        run_instr(16'h2220);
        chk_reg("add_dbl2_r2", 4'd2, 8'h10);
        run_instr(16'h5123);
        chk("sw_we_cnt", 16'(g_we), 16'd1);
        chk("sw_addr", 16'(g_addr), 16'h13);
        chk("sw_wdata", 16'(g_wdata), 16'h05);
        chk("sw_out", 16'(out), 16'h13);
        chk("sw_pc_cnt", 16'(g_pc), 16'd1);
        chk("sw_addr_hold", 16'(mem_addr), 16'h13);
        chk_reg("sw_r1_kept", 4'd1, 8'h05);
        chk_reg("sw_r2_kept", 4'd2, 8'h10);

        // Back-to-back with instr_valid held high
        prog[0] = 16'h4501;
        prog[1] = 16'h4502;
        prog[2] = 16'h2650;
        rdy_cnt = 0;
        pc_cnt  = 0;
        k       = 0;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            rdy_cnt += int'(instr_ready);
            pc_cnt  += int'(pc_inc);
            if (instr_ready && k < 3) begin
                instr       = prog[k];
                instr_valid = 1'b1;
                k++;
            end
        end
        @(negedge clk);
        instr_valid = 1'b0;
        chk("b2b_ready_cycles", 16'(rdy_cnt), 16'd3);
        chk("b2b_pc_cnt", 16'(pc_cnt), 16'd3);
        chk_reg("b2b_r5", 4'd5, 8'h03);
        chk_reg("b2b_r6", 4'd6, 8'h03);

        // Undefined opcode 0x7
        run_instr(16'h7123);
        chk("ill_cnt", 16'(g_ill), 16'd1);
        chk("ill_pc_cnt", 16'(g_pc), 16'd1);
        chk("ill_we_cnt", 16'(g_we), 16'd0);
        chk("ill_out_kept", 16'(out), 16'h03);
        chk_reg("ill_r1_kept", 4'd1, 8'h05);

        // Reset during EXEC of ADDI r4,+2
        @(negedge clk);
        instr       = 16'h4402;
        instr_valid = 1'b1;
        @(posedge clk);
        #1 instr_valid = 1'b0;
        @(posedge clk);
        #1 rst = 1'b0;
        pc_cnt = 0;
        repeat (2) begin
            @(negedge clk);
            pc_cnt += int'(pc_inc);
        end
        chk("abort_pc_cnt", 16'(pc_cnt), 16'd0);
        chk("abort_ready", 16'(instr_ready), 16'd1);
        chk("abort_out", 16'(out), 16'h00);
        chk_reg("abort_r4", 4'd4, 8'h00);
        chk_reg("abort_r1_cleared", 4'd1, 8'h00);
        @(negedge clk);
        rst = 1'b1;
        run_instr(16'h4402);
        chk_reg("restart_r4", 4'd4, 8'h02);
        chk("restart_pc_cnt", 16'(g_pc), 16'd1);
        chk("restart_out", 16'(out), 16'h02);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
